jtag_tap_responder: RTL and testbench



---
 rtl/jtag_tap_responder_pkg.sv | 57 +++++
 rtl/jtag_tap_responder_in_sync.sv | 38 +++
 rtl/jtag_tap_responder.sv | 138 +++++++++++++
 tb/tb_jtag_tap_responder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/jtag_tap_responder_pkg.sv
// Shared TAP definitions: 1149.1 state encoding, next-state function, DR select.
package jtag_tap_responder_pkg;

  localparam int TAP_STATE_W = 4;
  localparam logic BYPASS_CAPTURE = 1'b0;
  localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

  typedef enum logic [TAP_STATE_W-1:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SH_DR    = 4'h2,
    EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR   = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SH_IR    = 4'hA,
    EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR   = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2
  } dr_sel_e;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      TLR:      n = tms ? TLR      : RTI;
      RTI:      n = tms ? SEL_DR   : RTI;
      SEL_DR:   n = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   n = tms ? EX1_DR   : SH_DR;
      SH_DR:    n = tms ? EX1_DR   : SH_DR;
      EX1_DR:   n = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: n = tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   n = tms ? UPD_DR   : SH_DR;
      UPD_DR:   n = tms ? SEL_DR   : RTI;
      SEL_IR:   n = tms ? TLR      : CAP_IR;
      CAP_IR:   n = tms ? EX1_IR   : SH_IR;
      SH_IR:    n = tms ? EX1_IR   : SH_IR;
      EX1_IR:   n = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: n = tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   n = tms ? UPD_IR   : SH_IR;
      UPD_IR:   n = tms ? SEL_DR   : RTI;
      default:  n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_responder_in_sync.sv
// Oversampling synchronizer for TCK/TMS/TDI plus TCK rise/fall detection.
module jtag_in_sync #(
  parameter int C_SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic tck_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tms,
  output logic tdi,
  output logic rise,
  output logic fall
);

  // All three pins share one pipe so TMS/TDI stay aligned with TCK.
  logic [C_SYNC_STAGES-1:0][2:0] sync_pipe;
  logic prev_tck;
  logic sync_tck;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_pipe <= '0;
      prev_tck  <= 1'b0;
    end else begin
      sync_pipe[0] <= {tck_i, tms_i, tdi_i};
      for (int i = 1; i < C_SYNC_STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
      prev_tck <= sync_tck;
    end
  end

  assign sync_tck = sync_pipe[C_SYNC_STAGES-1][2];
  assign tms      = sync_pipe[C_SYNC_STAGES-1][1];
  assign tdi      = sync_pipe[C_SYNC_STAGES-1][0];
  assign rise     = sync_tck & ~prev_tck;
  assign fall     = ~sync_tck & prev_tck;

endmodule

// File: rtl/jtag_tap_responder.sv
// Target-side JTAG TAP: 1149.1 controller with IR, BYPASS, IDCODE and one USER DR.
module jtag_tap_responder
  import jtag_tap_responder_pkg::*;
#(
  parameter int                    C_IR_WIDTH     = 6,
  parameter int                    C_DR_WIDTH     = 32,
  parameter logic [31:0]           C_IDCODE       = 32'h0372_2093,
  parameter logic [C_IR_WIDTH-1:0] C_INSTR_IDCODE = 6'b001001,
  parameter logic [C_IR_WIDTH-1:0] C_INSTR_USER   = 6'b000010,
  parameter int                    C_SYNC_STAGES  = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  tck_i,
  input  logic                  tms_i,
  input  logic                  tdi_i,
  output logic                  tdo_o,
  output logic                  tdo_oe_o,
  output logic [3:0]            state_o,
  output logic [C_IR_WIDTH-1:0] ir_o,
  input  logic [C_DR_WIDTH-1:0] dr_capture_i,
  output logic [C_DR_WIDTH-1:0] dr_o,
  output logic                  dr_update_o
);

  localparam logic [C_IR_WIDTH-1:0] IR_CAPTURE = {{(C_IR_WIDTH-2){1'b0}}, IR_CAPTURE_LSBS};

  logic tms, tdi, rise, fall;
  tap_state_e state, state_nxt;
  dr_sel_e sel;
  logic [C_IR_WIDTH-1:0] ir_sr;
  logic [31:0] idcode_sr;
  logic [C_DR_WIDTH-1:0] user_sr;
  logic bypass_sr;
  logic tdo_nxt, oe_nxt;

  jtag_in_sync #(.C_SYNC_STAGES(C_SYNC_STAGES)) u_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .tck_i   (tck_i),
    .tms_i   (tms_i),
    .tdi_i   (tdi_i),
    .tms     (tms),
    .tdi     (tdi),
    .rise    (rise),
    .fall    (fall)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= TLR;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rise) state_nxt = tap_next(state, tms);
  end

  always_comb begin
    if (ir_o == C_INSTR_USER)        sel = DR_USER;
    else if (ir_o == C_INSTR_IDCODE) sel = DR_IDCODE;
    else                             sel = DR_BYPASS;
  end

  always_comb begin
    tdo_nxt = 1'b0;
    oe_nxt  = 1'b0;
    case (state)
      SH_IR: begin
        tdo_nxt = ir_sr[0];
        oe_nxt  = 1'b1;
      end
      SH_DR: begin
        oe_nxt = 1'b1;
        case (sel)
          DR_IDCODE: tdo_nxt = idcode_sr[0];
          DR_USER:   tdo_nxt = user_sr[0];
          default:   tdo_nxt = bypass_sr;
        endcase
      end
      default: ;
    endcase
  end

  // Register actions use the state held before the rise that triggers them.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ir_sr       <= '0;
      ir_o        <= C_INSTR_IDCODE;
      idcode_sr   <= '0;
      user_sr     <= '0;
      bypass_sr   <= 1'b0;
      dr_o        <= '0;
      dr_update_o <= 1'b0;
      tdo_o       <= 1'b0;
      tdo_oe_o    <= 1'b0;
    end else begin
      dr_update_o <= 1'b0;
      if (rise) begin
        case (state)
          CAP_IR: ir_sr <= IR_CAPTURE;
          SH_IR:  ir_sr <= {tdi, ir_sr[C_IR_WIDTH-1:1]};
          CAP_DR: begin
            case (sel)
              DR_IDCODE: idcode_sr <= C_IDCODE;
              DR_USER:   user_sr   <= dr_capture_i;
              default:   bypass_sr <= BYPASS_CAPTURE;
            endcase
          end
          SH_DR: begin
            case (sel)
              DR_IDCODE: idcode_sr <= {tdi, idcode_sr[31:1]};
              DR_USER:   user_sr   <= (user_sr >> 1) |
                                      (C_DR_WIDTH'(tdi) << (C_DR_WIDTH-1));
              default:   bypass_sr <= tdi;
            endcase
          end
          UPD_IR: ir_o <= ir_sr;
          UPD_DR: begin
            if (sel == DR_USER) begin
              dr_o        <= user_sr;
              dr_update_o <= 1'b1;
            end
          end
          default: ;
        endcase
        if (state_nxt == TLR) ir_o <= C_INSTR_IDCODE;
      end
      if (fall) begin
        tdo_o    <= tdo_nxt;
        tdo_oe_o <= oe_nxt;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench: drives TCK/TMS/TDI as a slow JTAG master and checks scans.
module tb_jtag_tap_responder;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        tck_i = 1'b0;
  logic        tms_i = 1'b0;
  logic        tdi_i = 1'b0;
  logic        tdo_o, tdo_oe_o;
  logic [3:0]  state_o;
  logic [5:0]  ir_o;
  logic [31:0] dr_capture_i = '0;
  logic [31:0] dr_o;
  logic        dr_update_o;

  int total = 0;
  int bad = 0;
  int hp = 4;
  int lp = 4;
  int upd_cnt = 0;
  logic [5:0][3:0] trace8;

  jtag_tap_responder dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .tck_i        (tck_i),
    .tms_i        (tms_i),
    .tdi_i        (tdi_i),
    .tdo_o        (tdo_o),
    .tdo_oe_o     (tdo_oe_o),
    .state_o      (state_o),
    .ir_o         (ir_o),
    .dr_capture_i (dr_capture_i),
    .dr_o         (dr_o),
    .dr_update_o  (dr_update_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (dr_update_o) upd_cnt <= upd_cnt + 1;

  // One TCK period; TDO/OE sampled at the end of the high phase.
  task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo, output logic oe);
    tms_i = tms;
    tdi_i = tdi;
    tck_i = 1'b1;
    repeat (hp) @(negedge clk_i);
    tdo = tdo_o;
    oe  = tdo_oe_o;
    tck_i = 1'b0;
    repeat (lp) @(negedge clk_i);
  endtask

  task automatic goto_tlr(output logic oe_any);
    logic t, o;
    oe_any = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tck_cycle(1'b1, 1'b0, t, o);
      oe_any |= o;
    end
  endtask

  // From RTI: full DR scan of n bits, returning to RTI.
  task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout,
                         output logic [5:0][3:0] tr, output logic oe_sh, output logic oe_other);
    logic t, o;
    dout = '0; oe_sh = 1'b1; oe_other = 1'b0;
    tck_cycle(1'b1, 1'b0, t, o); tr[0] = state_o; oe_other |= o;
    tck_cycle(1'b0, 1'b0, t, o); tr[1] = state_o; oe_other |= o;
    tck_cycle(1'b0, 1'b0, t, o); tr[2] = state_o; oe_other |= o;
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], t, o);
      dout[i] = t;
      oe_sh &= o;
    end
    tr[3] = state_o;
    tck_cycle(1'b1, 1'b0, t, o); tr[4] = state_o; oe_other |= o;
    tck_cycle(1'b0, 1'b0, t, o); tr[5] = state_o; oe_other |= o;
  endtask

  task automatic scan_ir(input logic [5:0] din, output logic [5:0] dout);
    logic t, o;
    tck_cycle(1'b1, 1'b0, t, o);
    tck_cycle(1'b1, 1'b0, t, o);
    tck_cycle(1'b0, 1'b0, t, o);
    tck_cycle(1'b0, 1'b0, t, o);
    for (int i = 0; i < 6; i++) begin
      tck_cycle(i == 5, din[i], t, o);
      dout[i] = t;
    end
    tck_cycle(1'b1, 1'b0, t, o);
    tck_cycle(1'b0, 1'b0, t, o);
  endtask

  task automatic test_reset();
    logic oe_any;
    reset_i = 1'b1;
    repeat (2) @(negedge clk_i);
    total++; if (state_o !== 4'hF) begin bad++; $display("FAIL reset_state got=%h exp=f", state_o); end
    total++; if (ir_o !== 6'b001001) begin bad++; $display("FAIL reset_ir got=%b exp=001001", ir_o); end
    total++; if (dr_o !== 32'h0) begin bad++; $display("FAIL reset_dr got=%h exp=0", dr_o); end
    total++; if ({tdo_o, tdo_oe_o, dr_update_o} !== 3'b000) begin
      bad++; $display("FAIL reset_outs got tdo/oe/upd=%b exp=000", {tdo_o, tdo_oe_o, dr_update_o});
    end
    reset_i = 1'b0;
    @(negedge clk_i);
    goto_tlr(oe_any);
    total++; if (state_o !== 4'hF) begin bad++; $display("FAIL tlr5_state got=%h exp=f", state_o); end
    total++; if (ir_o !== 6'b001001) begin bad++; $display("FAIL tlr5_ir got=%b exp=001001", ir_o); end
    total++; if (oe_any !== 1'b0) begin bad++; $display("FAIL tlr5_oe got=%b exp=0", oe_any); end
  endtask

  task automatic test_idcode();
    logic t, o, oe_sh, oe_other;
    logic [31:0] dout;
    tck_cycle(1'b0, 1'b0, t, o);
    total++; if (state_o !== 4'hC) begin bad++; $display("FAIL idc_rti got=%h exp=c", state_o); end
    scan_dr(32, 32'h0, dout, trace8, oe_sh, oe_other);
    total++; if (dout !== 32'h0372_2093) begin bad++; $display("FAIL idc_data got=%h exp=03722093", dout); end
    total++; if (trace8 !== 24'hC51267) begin bad++; $display("FAIL idc_trace got=%h exp=c51267", trace8); end
    total++; if (oe_sh !== 1'b1) begin bad++; $display("FAIL idc_oe_shift got=%b exp=1", oe_sh); end
    total++; if (oe_other !== 1'b0) begin bad++; $display("FAIL idc_oe_other got=%b exp=0", oe_other); end
  endtask

  task automatic test_bypass();
    logic [5:0] irout;
    logic [31:0] dout;
    logic [5:0][3:0] tr;
    logic oe_sh, oe_other;
    scan_ir(6'b111111, irout);
    total++; if (irout !== 6'b000001) begin bad++; $display("FAIL ir_capture got=%b exp=000001", irout); end
    total++; if (ir_o !== 6'h3F) begin bad++; $display("FAIL ir_update got=%h exp=3f", ir_o); end
    total++; if (state_o !== 4'hC) begin bad++; $display("FAIL ir_end got=%h exp=c", state_o); end
    scan_dr(8, 32'h0000_00A5, dout, tr, oe_sh, oe_other);
    total++; if (dout !== 32'h0000_004A) begin bad++; $display("FAIL bypass_data got=%h exp=0000004a", dout); end
  endtask

  task automatic test_user();
    logic [5:0] irout;
    logic [31:0] dout;
    logic [5:0][3:0] tr;
    logic oe_sh, oe_other;
    int cnt0;
    scan_ir(6'b000010, irout);
    total++; if (ir_o !== 6'b000010) begin bad++; $display("FAIL user_ir got=%b exp=000010", ir_o); end
    dr_capture_i = 32'h1234_5678;
    cnt0 = upd_cnt;
    total++; if (dr_o !== 32'h0) begin bad++; $display("FAIL user_pre_dr got=%h exp=0", dr_o); end
    scan_dr(32, 32'hDEAD_BEEF, dout, tr, oe_sh, oe_other);
    total++; if (dout !== 32'h1234_5678) begin bad++; $display("FAIL user_capture got=%h exp=12345678", dout); end
    total++; if (dr_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL user_update got=%h exp=deadbeef", dr_o); end
    total++; if (upd_cnt - cnt0 != 1) begin bad++; $display("FAIL user_pulse got=%0d cycles exp=1", upd_cnt - cnt0); end
  endtask

  task automatic test_reset_mid_shift();
    logic t, o, oe_sh, oe_other;
    logic [31:0] dout;
    logic [5:0][3:0] tr;
    tck_cycle(1'b1, 1'b0, t, o);
    tck_cycle(1'b0, 1'b0, t, o);
    tck_cycle(1'b0, 1'b0, t, o);
    for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'b1, t, o);
    total++; if ({state_o, tdo_oe_o} !== 5'b0010_1) begin
      bad++; $display("FAIL mid_pre got state/oe=%h/%b exp=2/1", state_o, tdo_oe_o);
    end
    reset_i = 1'b1;
    @(negedge clk_i);
    total++; if (state_o !== 4'hF) begin bad++; $display("FAIL mid_state got=%h exp=f", state_o); end
    total++; if (ir_o !== 6'b001001) begin bad++; $display("FAIL mid_ir got=%b exp=001001", ir_o); end
    total++; if (dr_o !== 32'h0) begin bad++; $display("FAIL mid_dr got=%h exp=0", dr_o); end
    total++; if (tdo_oe_o !== 1'b0) begin bad++; $display("FAIL mid_oe got=%b exp=0", tdo_oe_o); end
    reset_i = 1'b0;
    @(negedge clk_i);
    tck_cycle(1'b0, 1'b0, t, o);
    scan_dr(32, 32'h0, dout, tr, oe_sh, oe_other);
    total++; if (dout !== 32'h0372_2093) begin bad++; $display("FAIL mid_idcode got=%h exp=03722093", dout); end
  endtask

  task automatic test_min_ratio();
    logic t, o, oe_any, oe_sh, oe_other;
    logic [31:0] dout;
    logic [5:0][3:0] tr;
    hp = 2;
    lp = 2;
    goto_tlr(oe_any);
    tck_cycle(1'b0, 1'b0, t, o);
    total++; if (state_o !== 4'hC) begin bad++; $display("FAIL min_rti got=%h exp=c", state_o); end
    scan_dr(32, 32'h0, dout, tr, oe_sh, oe_other);
    total++; if (dout !== 32'h0372_2093) begin bad++; $display("FAIL min_idcode got=%h exp=03722093", dout); end
    total++; if (tr !== 24'hC51267) begin bad++; $display("FAIL min_trace got=%h exp=c51267", tr); end
    total++; if (tr !== trace8) begin bad++; $display("FAIL min_vs_ratio8 got=%h exp=%h", tr, trace8); end
    total++; if ({oe_sh, oe_other} !== 2'b10) begin bad++; $display("FAIL min_oe got=%b exp=10", {oe_sh, oe_other}); end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_idcode();
    test_bypass();
    test_user();
    test_reset_mid_shift();
    test_min_ratio();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
